decode_stage: RTL
=================

# decode_stage

Registered, handshaked RV32I/RV64I instruction decode stage that sits between the fetch unit and the register-read/execute stage. It accepts one fetched instruction word plus its PC per transfer, splits out register indices and function fields, builds the sign/zero-extended immediate at XLEN width, classifies the instruction and flags illegal encodings. A 2-entry output buffer (output register plus skid register) gives full throughput under backpressure, and a flush input kills in-flight instructions on redirect.

## Interface
- XLEN, 32, datapath width for imm and pc; legal values 32 or 64 (64 enables OP-IMM-32/OP-32 and 6-bit shamt).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop every buffered and incoming instruction this cycle.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_pc  out  XLEN  passthrough pc.
- out_opcode  out  7 / out_funct3  out  3 / out_funct7  out  7  raw fields inst[6:0], [14:12], [31:25].
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], [24:20], [11:7].
- out_imm  out  XLEN  decoded immediate.
- out_type  out  4  class: 0 R, 1 I-alu, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 FENCE, 10 SYSTEM, 11 I-alu-32, 12 R-32, 15 illegal.
- out_illegal  out  1  encoding not legal for configured XLEN.

## Operation
- Immediates, sign bit inst[31] extended to XLEN:
  - I/LOAD/JALR/FENCE/SYSTEM: inst[31:20].
  - STORE: {inst[31:25], inst[11:7]}.
  - BRANCH: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - LUI/AUIPC: {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - JAL: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R, R-32, illegal: 0.
- Shift-immediates (I-alu funct3 001/101, I-alu-32 same): imm = zero-extended shamt; shamt is inst[24:20] for XLEN=32 and for I-alu-32, inst[25:20] for XLEN=64 I-alu.
- Illegal when any of:
  - opcode not in the supported set;
  - R funct7 not 0000000, or 0100000 with funct3 other than 000/101;
  - shift-immediate upper bits (inst[31:25], or inst[31:26] for 6-bit shamt) not 0000000/0100000 pattern, or 0100000 with funct3 001;
  - LOAD funct3 011/110 with XLEN=32, or 111;
  - STORE funct3 >= 100 (>= 011 for XLEN=32);
  - BRANCH funct3 010/011;
  - JALR funct3 != 000;
  - opcodes 0011011/0111011 with XLEN=32.
  - Illegal forces out_type=15 and imm=0; fields still pass through.
- Buffer: 2 entries (OUT register, SKID register). in_ready = !skid_full (registered, no combinational path from out_ready).
  - Accept with OUT empty or OUT draining this cycle, SKID empty → write OUT.
  - Accept while OUT holds and is stalled → write SKID.
  - OUT drains with SKID full → SKID moves to OUT, SKID empties.
  - Order always preserved.
- flush: both entries invalid next cycle; an input handshaking in the flush cycle is dropped; in_ready=1 next cycle.

## Timing
- Reset: out_valid=0, skid empty, in_ready=1 in the cycle after rst; all data outputs 0.
- rst dominates flush and handshakes; reset mid-stream discards all entries.
- Latency 1 cycle: inst accepted in cycle N appears on out_* in N+1.
- Throughput 1/cycle with out_ready held high.
- out_* stable while out_valid && !out_ready.
- in_ready deasserts the cycle after SKID fills; reasserts the cycle after SKID drains.

## Test plan
- Reset then idle → out_valid=0, in_ready=1, out_imm=0.
- Stream addi x1,x0,-1 (0xFFF00093), sw x2,8(x1) (0x0020A423), beq x0,x0,-4 (0xFE000EE3), jal x1,2048 (0x001000EF... per encoding) with out_ready=1 → one per cycle, imm 0xFFFFFFFF, 8, 0xFFFFFFFC, 0x800, types 1,3,4,7.
- srai x1,x1,3 (0x4030D093) → imm=3, illegal=0; 0x00000000 and 0x0000707F → illegal=1, type=15, imm=0.
- out_ready low 3 cycles under continuous input → in_ready drops after 2 accepted; release → original order, no loss, no duplicate.
- flush asserted with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, flushed instructions never appear.
- XLEN=64: lui x1,0x80000 (0x800000B7) → imm 0xFFFFFFFF80000000; slli x1,x1,33 (0x02109093) legal, imm=33; XLEN=32 same word → illegal.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, decode_stage and the register-read stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_type;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_type, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode into a 2-entry (out + skid) buffer.
module decode_stage #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_R32   = 7'b0111011;

  typedef enum logic [3:0] {
    T_R     = 4'd0,
    T_I     = 4'd1,
    T_LOAD  = 4'd2,
    T_STORE = 4'd3,
    T_BR    = 4'd4,
    T_LUI   = 4'd5,
    T_AUIPC = 4'd6,
    T_JAL   = 4'd7,
    T_JALR  = 4'd8,
    T_FENCE = 4'd9,
    T_SYS   = 4'd10,
    T_I32   = 4'd11,
    T_R32   = 4'd12,
    T_ILL   = 4'd15
  } itype_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    itype_e          typ;
    logic            illegal;
  } dec_t;

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // inst[31] sits in the replication so every form works for XLEN=32 and 64.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6;
  assign imm_i  = {{(XLEN-11){inst[31]}}, inst[30:20]};
  assign imm_s  = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};

  logic is_shift, r_bad, sh7_bad, sh6_bad;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign r_bad    = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
  // Only the arithmetic right shift may set the 0100000 pattern.
  assign sh7_bad  = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b001);
  assign sh6_bad  = !((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000)) ||
                    (inst[31:26] == 6'b010000 && funct3 == 3'b001);

  itype_e          typ;
  logic [XLEN-1:0] imm;
  logic            bad;

  always_comb begin
    typ = T_ILL;
    imm = '0;
    bad = 1'b0;
    case (opcode)
      OP_R:     begin typ = T_R;   bad = r_bad; end
      OP_R32:   begin typ = T_R32; bad = r_bad || !RV64; end
      OP_IMM: begin
        typ = T_I;
        if (is_shift) begin
          imm = RV64 ? shamt6 : shamt5;
          bad = RV64 ? sh6_bad : sh7_bad;
        end else begin
          imm = imm_i;
        end
      end
      OP_IMM32: begin
        typ = T_I32;
        imm = is_shift ? shamt5 : imm_i;
        bad = !RV64 || (is_shift && sh7_bad);
      end
      OP_LOAD: begin
        typ = T_LOAD;
        imm = imm_i;
        bad = (funct3 == 3'b111) || (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OP_STORE: begin
        typ = T_STORE;
        imm = imm_s;
        bad = RV64 ? funct3[2] : (funct3 >= 3'b011);
      end
      OP_BR:    begin typ = T_BR;    imm = imm_b; bad = (funct3[2:1] == 2'b01); end
      OP_LUI:   begin typ = T_LUI;   imm = imm_u; end
      OP_AUIPC: begin typ = T_AUIPC; imm = imm_u; end
      OP_JAL:   begin typ = T_JAL;   imm = imm_j; end
      OP_JALR:  begin typ = T_JALR;  imm = imm_i; bad = (funct3 != 3'b000); end
      OP_FENCE: begin typ = T_FENCE; imm = imm_i; end
      OP_SYS:   begin typ = T_SYS;   imm = imm_i; end
      default:  bad = 1'b1;
    endcase
    if (bad) begin
      typ = T_ILL;
      imm = '0;
    end
  end

  dec_t dec;
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = opcode;
    dec.funct3  = funct3;
    dec.funct7  = funct7;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];
    dec.imm     = imm;
    dec.typ     = typ;
    dec.illegal = bad;
  end

  // in_ready is the registered skid-empty flag, so out_ready never reaches it combinationally.
  dec_t out_q, skid_q;
  logic out_v, skid_v, accept, drain;

  assign accept = bus.in_valid && !skid_v;
  assign drain  = out_v && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_v;
  assign bus.out_valid   = out_v;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_funct7  = out_q.funct7;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_type    = out_q.typ;
  assign bus.out_illegal = out_q.illegal;
endmodule
